alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-to-execute issue register for the ALU. It accepts a decoded instruction word plus both register-file operands over a valid/ready handshake and translates opcode/funct3/funct7 into the 3-bit ALU control code. It selects and sign-extends the second operand, then presents control and operands to the ALU through a registered, two-entry skid-buffered output. It sits between the register-file read stage and the ALU, and is the producer side of the ALU control interface.

## Interface
- `XLEN`, default 32: operand and data width.
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `in_valid_i`, in, 1: upstream holds a valid instruction.
- `in_ready_o`, out, 1: stage can accept; registered.
- `instr_i`, in, 32: RV32 instruction word.
- `rs1_data_i`, in, XLEN: rs1 operand.
- `rs2_data_i`, in, XLEN: rs2 operand.
- `flush_i`, in, 1: synchronous kill of all held entries.
- `out_valid_o`, out, 1: ALU inputs valid.
- `out_ready_i`, in, 1: execute stage consumes this cycle.
- `ALUCtrl_o`, out, 3: ALU control code.
- `data1_o`, out, XLEN: ALU operand 1, always rs1.
- `data2_o`, out, XLEN: ALU operand 2, either rs2 or the immediate.
- `illegal_o`, out, 1: the held entry is an unsupported instruction.

## Operation
- Control codes: SUM=001, SUB=010, AND=011, OR=100, XOR=101, MUL=110, and 000 for illegal (the ALU then passes data1).
- Opcode 0110011 (R-type), operand 2 = rs2:
  - funct7=0000000: funct3 000→SUM, 100→XOR, 110→OR, 111→AND.
  - funct7=0100000 with funct3 000 → SUB.
  - funct7=0000001 with funct3 000 → MUL.
  - Any other combination is illegal.
- Opcode 0010011 (I-type), operand 2 = sext(instr[31:20]): funct3 000→SUM, 100→XOR, 110→OR, 111→AND; other funct3 values are illegal.
- Opcode 0000011 (load): SUM, operand 2 = sext(instr[31:20]).
- Opcode 0100011 (store): SUM, operand 2 = sext({instr[31:25],instr[11:7]}).
- Opcode 1100011 (branch): SUB, operand 2 = rs2. The ALU's Zero flag resolves beq/bne.
- Any other opcode: code 000, operand 2 = rs2, illegal_o=1.
- Sign extension replicates bit 11 of the immediate up to XLEN-1.
- Decode is combinational on the input side. Only registered values appear on the outputs.
- Storage is a main entry (drives the outputs) plus one skid entry.
- Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
- Transfer in when main is empty, or main is transferring out with skid empty: the decoded entry loads main.
- Transfer in while main is full and not transferring out: the entry loads skid.
- Transfer out with skid full: skid moves to main, and skid empties.
- in_ready_o = !skid_valid (registered), so at most one extra entry is accepted after out_ready_i drops.
- flush_i: at the next edge both entries are invalidated. Any transfer in during the same cycle is accepted and discarded. Flush has priority over every other update.
- Held payload (ALUCtrl_o/data/illegal_o) stays stable while out_valid_o=1 and out_ready_i=0.

## Timing
- Reset (asynchronous, immediate): out_valid_o=0, skid empty, in_ready_o=1, ALUCtrl_o=000, data1_o=0, data2_o=0, illegal_o=0.
- Latency: input accepted at edge N → out_valid_o=1 with the decoded payload after edge N.
- Throughput is one instruction per cycle when out_ready_i=1 continuously.
- Back-pressure: out_ready_i low while main is full → one more entry can enter skid. in_ready_o falls the cycle after skid fills, and rises the cycle after skid drains.
- Simultaneous transfer in and transfer out with skid empty: main is replaced by the new entry, and out_valid_o stays 1.
- Simultaneous transfer in and transfer out with skid full cannot occur, because in_ready_o=0.
- Reset asserted mid-stream drops all entries with no partial output. After deassertion, the first accept yields output one cycle later.
- Payload registers do not need to clear when invalid; only the valid bits matter after reset.

## Test plan
- Reset check: assert rst_i mid-transfer → outputs immediately show out_valid_o=0, in_ready_o=1, ALUCtrl_o=000, data1_o=0, data2_o=0, illegal_o=0.
- Streaming decode, out_ready_i=1:
  - add (0x002081B3) → SUM after 1 cycle.
  - sub (0x402081B3) → SUB.
  - mul (0x022081B3) → MUL.
  - and/or/xor → 011/100/101.
  - beq → SUB.
  - One result per cycle, in order.
- Immediates:
  - addi x1,x2,-1 (0xFFF10093), rs1=5 → SUM, data2_o=0xFFFFFFFF.
  - sw with offset -4 → SUM, data2_o=0xFFFFFFFC.
  - lw offset 0x7FF → data2_o=0x000007FF.
- Illegal: opcode 0110111, and R-type funct7=0100000 with funct3=111 → ALUCtrl_o=000, illegal_o=1, out_valid_o=1.
- Back-pressure:
  - Drop out_ready_i with a stream of 4 instructions → second enters skid, in_ready_o=0 next cycle, output held stable.
  - Raise out_ready_i → all 4 delivered in order, none lost or duplicated.
- Flush: main and skid full, assert flush_i together with in_valid_i → next cycle out_valid_o=0, in_ready_o=1, and the flushed-cycle input never appears.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue register: decodes RV32 opcode/funct fields into a 3-bit ALU control code,
// selects operand 2, and holds results in a main entry plus one skid entry.
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [2:0]      ALUCtrl_o,
   output logic [XLEN-1:0] data1_o,
   output logic [XLEN-1:0] data2_o,
   output logic            illegal_o
);

   localparam logic [2:0] CTL_NOP = 3'b000;
   localparam logic [2:0] CTL_SUM = 3'b001;
   localparam logic [2:0] CTL_SUB = 3'b010;
   localparam logic [2:0] CTL_AND = 3'b011;
   localparam logic [2:0] CTL_OR  = 3'b100;
   localparam logic [2:0] CTL_XOR = 3'b101;
   localparam logic [2:0] CTL_MUL = 3'b110;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [2:0]      ctrl;
      logic            ill;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
   } entry_t;

   entry_t main_q, skid_q, dec;
   logic   main_valid, skid_valid;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};

   always_comb begin
      dec.ctrl = CTL_NOP;
      dec.ill  = 1'b0;
      dec.d1   = rs1_data_i;
      dec.d2   = rs2_data_i;
      case (opcode)
         OP_R: begin
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: dec.ctrl = CTL_SUM;
               {7'b0000000, 3'b100}: dec.ctrl = CTL_XOR;
               {7'b0000000, 3'b110}: dec.ctrl = CTL_OR;
               {7'b0000000, 3'b111}: dec.ctrl = CTL_AND;
               {7'b0100000, 3'b000}: dec.ctrl = CTL_SUB;
               {7'b0000001, 3'b000}: dec.ctrl = CTL_MUL;
               default:              dec.ill  = 1'b1;
            endcase
         end
         OP_I: begin
            dec.d2 = imm_i;
            case (funct3)
               3'b000:  dec.ctrl = CTL_SUM;
               3'b100:  dec.ctrl = CTL_XOR;
               3'b110:  dec.ctrl = CTL_OR;
               3'b111:  dec.ctrl = CTL_AND;
               default: dec.ill  = 1'b1;
            endcase
         end
         OP_LOAD: begin
            dec.ctrl = CTL_SUM;
            dec.d2   = imm_i;
         end
         OP_STORE: begin
            dec.ctrl = CTL_SUM;
            dec.d2   = imm_s;
         end
         OP_BRANCH: dec.ctrl = CTL_SUB;
         default:   dec.ill  = 1'b1;
      endcase
   end

   logic xfer_in, xfer_out;
   assign xfer_in  = in_valid_i & in_ready_o;
   assign xfer_out = main_valid & out_ready_i;

   // Skid can only be full while main is full, so a drain always refills main from skid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush_i) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (xfer_out && skid_valid) begin
         main_q     <= skid_q;
         skid_valid <= 1'b0;
      end else if (xfer_in && (!main_valid || xfer_out)) begin
         main_q     <= dec;
         main_valid <= 1'b1;
      end else if (xfer_in) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end else if (xfer_out) begin
         main_valid <= 1'b0;
      end
   end

   assign in_ready_o  = !skid_valid;
   assign out_valid_o = main_valid;
   assign ALUCtrl_o   = main_q.ctrl;
   assign data1_o     = main_q.d1;
   assign data2_o     = main_q.d2;
   assign illegal_o   = main_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed driver pushes expected entries into a queue,
// an independent monitor compares every presented output against the queue head.
module tb_alu_issue_stage;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] instr_i = '0;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic        flush_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [2:0]  ALUCtrl_o;
   logic [31:0] data1_o, data2_o;
   logic        illegal_o;

   typedef struct packed {
      logic [2:0]  ctrl;
      logic        ill;
      logic [31:0] d1;
      logic [31:0] d2;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   alu_issue_stage #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .ALUCtrl_o(ALUCtrl_o), .data1_o(data1_o), .data2_o(data2_o),
      .illegal_o(illegal_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every presented output must match the queue head; pop on consume.
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got ctrl=%0h d1=%0h d2=%0h ill=%0b with nothing expected",
                     ALUCtrl_o, data1_o, data2_o, illegal_o);
         end else begin
            exp_t e;
            e = exp_q[0];
            if ({ALUCtrl_o, illegal_o, data1_o, data2_o} !== e) begin
               bad++;
               $display("FAIL output: got ctrl=%0h ill=%0b d1=%0h d2=%0h expected ctrl=%0h ill=%0b d1=%0h d2=%0h",
                        ALUCtrl_o, illegal_o, data1_o, data2_o, e.ctrl, e.ill, e.d1, e.d2);
            end
            if (out_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic [31:0] d2, input logic il);
      int t;
      exp_t e;
      t = 0;
      in_valid_i = 1'b1; instr_i = ins; rs1_data_i = a; rs2_data_i = b;
      @(negedge clk_i);
      while (!in_ready_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      if (!in_ready_o) begin
         total++; bad++;
         $display("FAIL issue_timeout: in_ready_o stayed 0 for instr %08h", ins);
      end else begin
         e.ctrl = c; e.ill = il; e.d1 = a; e.d2 = d2;
         exp_q.push_back(e);
      end
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge clk_i); #1;
         t++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
      check({tag, "_in_ready"},  64'(in_ready_o),  64'd1);
      check({tag, "_ctrl"},      64'(ALUCtrl_o),   64'd0);
      check({tag, "_data1"},     64'(data1_o),     64'd0);
      check({tag, "_data2"},     64'(data2_o),     64'd0);
      check({tag, "_illegal"},   64'(illegal_o),   64'd0);
   endtask

   initial begin
      int c0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Streaming R-type/branch decode, one per cycle.
      c0 = cyc;
      issue(32'h002081B3, 32'd10, 32'd3, 3'b001, 32'd3, 1'b0); // add
      issue(32'h402081B3, 32'd10, 32'd3, 3'b010, 32'd3, 1'b0); // sub
      issue(32'h022081B3, 32'd7,  32'd6, 3'b110, 32'd6, 1'b0); // mul
      issue(32'h0020F1B3, 32'hF0, 32'h3C, 3'b011, 32'h3C, 1'b0); // and
      issue(32'h0020E1B3, 32'hF0, 32'h3C, 3'b100, 32'h3C, 1'b0); // or
      issue(32'h0020C1B3, 32'hF0, 32'h3C, 3'b101, 32'h3C, 1'b0); // xor
      issue(32'h00208063, 32'd9,  32'd9, 3'b010, 32'd9, 1'b0);   // beq
      check("stream_throughput_cycles", 64'(cyc - c0), 64'd7);
      drain("stream_drain");

      // Immediates
      issue(32'hFFF10093, 32'd5, 32'h1234, 3'b001, 32'hFFFFFFFF, 1'b0); // addi -1
      issue(32'hFE20AE23, 32'h100, 32'hAA, 3'b001, 32'hFFFFFFFC, 1'b0); // sw -4
      issue(32'h7FF12083, 32'h200, 32'hBB, 3'b001, 32'h000007FF, 1'b0); // lw 0x7FF
      // Illegal
      issue(32'h000010B7, 32'd1, 32'd2, 3'b000, 32'd2, 1'b1); // lui
      issue(32'h4020F1B3, 32'd1, 32'd4, 3'b000, 32'd4, 1'b1); // funct7=0100000 funct3=111
      drain("imm_illegal_drain");

      // Back-pressure: second entry lands in skid, in_ready_o drops.
      out_ready_i = 1'b0;
      issue(32'h002081B3, 32'd1, 32'd11, 3'b001, 32'd11, 1'b0);
      issue(32'h402081B3, 32'd2, 32'd12, 3'b010, 32'd12, 1'b0);
      check("bp_in_ready_low", 64'(in_ready_o), 64'd0);
      check("bp_out_valid", 64'(out_valid_o), 64'd1);
      fork
         begin
            issue(32'h0020C1B3, 32'd3, 32'd13, 3'b101, 32'd13, 1'b0);
            issue(32'h0020E1B3, 32'd4, 32'd14, 3'b100, 32'd14, 1'b0);
         end
         begin
            repeat (3) @(posedge clk_i);
            #2;
            check("bp_held_in_ready", 64'(in_ready_o), 64'd0);
            check("bp_held_qsize", 64'(exp_q.size()), 64'd2);
            out_ready_i = 1'b1;
         end
      join
      drain("bp_drain");

      // Flush with main+skid full while offering a new input.
      out_ready_i = 1'b0;
      issue(32'h002081B3, 32'd21, 32'd31, 3'b001, 32'd31, 1'b0);
      issue(32'h002081B3, 32'd22, 32'd32, 3'b001, 32'd32, 1'b0);
      in_valid_i = 1'b1; instr_i = 32'h402081B3; rs1_data_i = 32'hDEAD; rs2_data_i = 32'hBEEF;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0; in_valid_i = 1'b0;
      exp_q.delete();
      check("flush_out_valid", 64'(out_valid_o), 64'd0);
      check("flush_in_ready", 64'(in_ready_o), 64'd1);

      // Flush with main full, skid empty: the same-cycle input is accepted then discarded.
      issue(32'h002081B3, 32'd23, 32'd33, 3'b001, 32'd33, 1'b0);
      in_valid_i = 1'b1; instr_i = 32'h402081B3; rs1_data_i = 32'hDEAD; rs2_data_i = 32'hBEEF;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0; in_valid_i = 1'b0;
      exp_q.delete();
      check("flush2_out_valid", 64'(out_valid_o), 64'd0);
      check("flush2_in_ready", 64'(in_ready_o), 64'd1);
      out_ready_i = 1'b1;
      issue(32'h0020F1B3, 32'd7, 32'd8, 3'b011, 32'd8, 1'b0);
      drain("post_flush_drain");

      // Asynchronous reset mid-stream.
      out_ready_i = 1'b0;
      issue(32'h002081B3, 32'd41, 32'd51, 3'b001, 32'd51, 1'b0);
      issue(32'h402081B3, 32'd42, 32'd52, 3'b010, 32'd52, 1'b0);
      in_valid_i = 1'b1; instr_i = 32'h022081B3; rs1_data_i = 32'd1; rs2_data_i = 32'd2;
      #2 rst_i = 1'b1;
      #1;
      in_valid_i = 1'b0;
      exp_q.delete();
      check_reset_outputs("midreset");
      @(posedge clk_i); #1 rst_i = 1'b0;
      out_ready_i = 1'b1;
      issue(32'h00208063, 32'd5, 32'd6, 3'b010, 32'd6, 1'b0);
      check("post_reset_latency_valid", 64'(out_valid_o), 64'd1);
      drain("post_reset_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
